// File: rtl/l1_pkg.sv
// Shared types and constants for the Layer 1 input queue and its controller.
package l1_pkg;

    // Width of a Layer 1 node index as seen on queueOut.
    localparam int NODE_ADDR_W = 10;

    // One buffered queue entry: node index plus end-of-frame marker.
    typedef struct packed {
        logic                   last;
        logic [NODE_ADDR_W-1:0] index;
    } queue_entry_t;

    // Frame-level state of the queue as presented to the controller.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } queue_state_e;

endpackage

// File: rtl/l1_queue_ram.sv
// Simple dual-port storage for the input queue: one synchronous write port and
// one registered read port. A read of the slot being written in the same cycle
// returns the new data, so the head register never holds a stale entry.
module l1_queue_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port: store the pushed entry.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Read port: register the addressed entry, forwarding a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (wrEn && (wrAddr == rdAddr)) begin
            rd_data_r <= wrData;
        end else begin
            rd_data_r <= mem_r[rdAddr];
        end
    end

    assign rdData = rd_data_r;

endmodule

// File: rtl/layer1_input_queue.sv
// Layer 1 input queue: buffers active-input node indices from the encoder and
// hands them to the Layer 1 controller one frame at a time.
// Optional feature macro: L1_QUEUE_DROP_COUNT_EN (counts rejected pushes on
// dropCount; when undefined dropCount is tied to zero).
module layer1_input_queue
    import l1_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = NODE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enqueue,
    input  logic [ADDR_W-1:0] enqueueData,
    input  logic              enqueueLast,
    output logic              queueFull,
    input  logic              dequeue,
    output logic [ADDR_W-1:0] queueOut,
    output logic              queueEmpty,
    output logic              inputsReady,
    input  logic              nextFrame,
    output logic [15:0]       dropCount
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    // Advance a pointer; DEPTH is a power of two so the natural wrap is DEPTH-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic [PTR_W:0]   frame_cnt_r;
    logic [PTR_W:0]   frame_cnt_nxt_s;
    queue_state_e     state_r;
    queue_state_e     state_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             ready_r;
    logic             push_s;
    logic             pop_s;
    logic             head_last_s;
    logic [ADDR_W:0]  head_s;

    // The head register in the RAM always holds the entry at the read pointer.
    assign head_last_s = head_s[ADDR_W];
    assign queueOut    = head_s[ADDR_W-1:0];
    assign queueFull   = full_r;
    assign queueEmpty  = empty_r;
    assign inputsReady = ready_r;

    // Accept decode: a pop frees a slot in the same cycle, so a full queue
    // still takes a push when it is popped at the same time.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (dequeue && !empty_r && (state_r == SERVE)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (enqueue && (!full_r || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next read pointer, occupancy and complete-frame count.
    always_comb begin
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;
        frame_cnt_nxt_s = frame_cnt_r;
        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        case ({push_s && enqueueLast, pop_s && head_last_s})
            2'b10: begin
                if (frame_cnt_r != CNT_FULL) begin
                    frame_cnt_nxt_s = frame_cnt_r + CNT_ONE;
                end else begin
                    frame_cnt_nxt_s = frame_cnt_r;
                end
            end
            2'b01:   frame_cnt_nxt_s = frame_cnt_r - CNT_ONE;
            default: frame_cnt_nxt_s = frame_cnt_r;
        endcase
    end

    // Frame state machine: next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (frame_cnt_r != CNT_ZERO) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            SERVE: begin
                if (pop_s && head_last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            DRAIN: begin
                if (nextFrame) begin
                    if (frame_cnt_r != CNT_ZERO) begin
                        state_nxt_s = SERVE;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State, pointer, counter and registered flag updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            frame_cnt_r <= CNT_ZERO;
            state_r     <= LOAD;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            wr_ptr_r    <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            state_r     <= state_nxt_s;
            full_r      <= (count_nxt_s == CNT_FULL);
            empty_r     <= (state_nxt_s != SERVE) || (count_nxt_s == CNT_ZERO);
            ready_r     <= (state_nxt_s == SERVE);
        end
    end

    // The RAM reads at the next read pointer so the head shows up one cycle
    // after a pop and is already present when the frame is released.
    l1_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 1)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (push_s),
        .wrAddr (wr_ptr_r),
        .wrData ({enqueueLast, enqueueData}),
        .rdAddr (rd_ptr_nxt_s),
        .rdData (head_s)
    );

`ifdef L1_QUEUE_DROP_COUNT_EN
    logic        drop_s;
    logic [15:0] drop_cnt_r;

    assign drop_s    = enqueue && !push_s;
    assign dropCount = drop_cnt_r;

    // Rejected-push counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end
`else
    assign dropCount = 16'h0000;
`endif

endmodule

// File: tb/tb_layer1_input_queue.sv
// Directed self-checking bench for layer1_input_queue (DEPTH 64, 10-bit index).
module tb_layer1_input_queue;
    import l1_pkg::*;

`ifdef L1_QUEUE_DROP_COUNT_EN
    localparam int DROP_EXP = 1;
`else
    localparam int DROP_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enqueue;
    logic [9:0]  enqueueData;
    logic        enqueueLast;
    logic        queueFull;
    logic        dequeue;
    logic [9:0]  queueOut;
    logic        queueEmpty;
    logic        inputsReady;
    logic        nextFrame;
    logic [15:0] dropCount;

    int cmp_cnt = 0;
    int err_cnt = 0;

    layer1_input_queue #(.DEPTH(64), .ADDR_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .enqueue     (enqueue),
        .enqueueData (enqueueData),
        .enqueueLast (enqueueLast),
        .queueFull   (queueFull),
        .dequeue     (dequeue),
        .queueOut    (queueOut),
        .queueEmpty  (queueEmpty),
        .inputsReady (inputsReady),
        .nextFrame   (nextFrame),
        .dropCount   (dropCount)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enqueue     = 1'b0;
        enqueueData = 10'd0;
        enqueueLast = 1'b0;
        dequeue     = 1'b0;
        nextFrame   = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic push(input int v, input bit last);
        enqueue     = 1'b1;
        enqueueData = v[9:0];
        enqueueLast = last;
        @(negedge clk);
        enqueue     = 1'b0;
        enqueueLast = 1'b0;
    endtask

    task automatic pop();
        dequeue = 1'b1;
        @(negedge clk);
        dequeue = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pushed;
        int popped;
        int cyc;
        bit full_seen;

        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Reset values, sampled while reset is held.
        check_val("rst_full",  32'(queueFull),   32'd0);
        check_val("rst_empty", 32'(queueEmpty),  32'd1);
        check_val("rst_ready", 32'(inputsReady), 32'd0);
        check_val("rst_out",   32'(queueOut),    32'd0);
        check_val("rst_drop",  32'(dropCount),   32'd0);
        check_val("rst_count", 32'(dut.count_r), 32'd0);
        check_val("rst_state", 32'(dut.state_r), 32'(LOAD));
        reset = 1'b0;
        cycle();

        // Frame 5, 17, 3(last): released two cycles after the last push.
        push(5, 1'b0);
        push(17, 1'b0);
        push(3, 1'b1);
        check_val("lat_ready1", 32'(inputsReady), 32'd0);
        cycle();
        check_val("lat_ready2", 32'(inputsReady), 32'd1);
        check_val("f1_out0",    32'(queueOut),    32'd5);
        check_val("f1_empty0",  32'(queueEmpty),  32'd0);
        pop();
        check_val("f1_out1", 32'(queueOut), 32'd17);
        pop();
        check_val("f1_out2", 32'(queueOut), 32'd3);
        pop();
        check_val("f1_drain_empty", 32'(queueEmpty),  32'd1);
        check_val("f1_drain_ready", 32'(inputsReady), 32'd0);
        dequeue = 1'b1;
        cycle();
        cycle();
        dequeue = 1'b0;
        check_val("f1_hold_empty", 32'(queueEmpty),  32'd1);
        check_val("f1_hold_state", 32'(dut.state_r), 32'(DRAIN));
        nextFrame = 1'b1;
        cycle();
        nextFrame = 1'b0;
        check_val("f1_load_state", 32'(dut.state_r), 32'(LOAD));
        check_val("f1_load_ready", 32'(inputsReady), 32'd0);
        check_val("f1_load_empty", 32'(queueEmpty),  32'd1);

        // Frame A {1, 2 last} and frame B {9 last}: boundary held until nextFrame.
        push(1, 1'b0);
        push(2, 1'b1);
        push(9, 1'b1);
        cycle();
        check_val("ab_out0", 32'(queueOut), 32'd1);
        pop();
        check_val("ab_out1", 32'(queueOut), 32'd2);
        pop();
        check_val("ab_drain_empty", 32'(queueEmpty),  32'd1);
        check_val("ab_drain_count", 32'(dut.count_r), 32'd1);
        check_val("ab_drain_ready", 32'(inputsReady), 32'd0);
        cycle();
        check_val("ab_hold_empty", 32'(queueEmpty), 32'd1);
        nextFrame = 1'b1;
        cycle();
        nextFrame = 1'b0;
        check_val("ab_b_ready", 32'(inputsReady), 32'd1);
        check_val("ab_b_empty", 32'(queueEmpty),  32'd0);
        check_val("ab_b_out",   32'(queueOut),    32'd9);

        // Fill all 64 entries; 65th push dropped; push+pop while full accepted.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            push(i, (i == 63));
        end
        check_val("fill_full",  32'(queueFull),   32'd1);
        check_val("fill_count", 32'(dut.count_r), 32'd64);
        enqueue     = 1'b1;
        enqueueData = 10'd777;
        cycle();
        enqueue = 1'b0;
        check_val("drop_full",  32'(queueFull),   32'd1);
        check_val("drop_count", 32'(dut.count_r), 32'd64);
        check_val("drop_cnt",   32'(dropCount),   32'(DROP_EXP));
        check_val("drop_empty", 32'(queueEmpty),  32'd0);
        check_val("drop_out",   32'(queueOut),    32'd0);
        enqueue     = 1'b1;
        enqueueData = 10'd700;
        dequeue     = 1'b1;
        cycle();
        enqueue = 1'b0;
        dequeue = 1'b0;
        check_val("pp_count", 32'(dut.count_r), 32'd64);
        check_val("pp_full",  32'(queueFull),   32'd1);
        check_val("pp_out",   32'(queueOut),    32'd1);
        check_val("pp_drop",  32'(dropCount),   32'(DROP_EXP));

        // Wrap: stream 100 entries in frames of four, popping continuously.
        do_reset();
        pushed    = 0;
        popped    = 0;
        cyc       = 0;
        full_seen = 1'b0;
        dequeue   = 1'b1;
        nextFrame = 1'b1;
        while ((popped < 100) && (cyc < 400)) begin
            if (queueFull) begin
                full_seen = 1'b1;
            end
            if (!queueEmpty) begin
                check_val("wrap_order", 32'(queueOut), 32'(300 + popped));
                popped++;
            end
            if ((pushed < 100) && !queueFull) begin
                enqueue     = 1'b1;
                enqueueData = 10'(300 + pushed);
                enqueueLast = ((pushed % 4) == 3);
                pushed++;
            end else begin
                enqueue     = 1'b0;
                enqueueLast = 1'b0;
            end
            cycle();
            cyc++;
        end
        idle();
        check_val("wrap_popped", 32'(popped),     32'd100);
        check_val("wrap_nofull", 32'(full_seen),  32'd0);
        cycle();
        check_val("wrap_end_count", 32'(dut.count_r), 32'd0);

        // Reset mid-SERVE with three entries left.
        do_reset();
        push(10, 1'b0);
        push(11, 1'b0);
        push(12, 1'b0);
        push(13, 1'b1);
        cycle();
        pop();
        check_val("ms_out",   32'(queueOut),    32'd11);
        check_val("ms_count", 32'(dut.count_r), 32'd3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_val("ms_rst_count", 32'(dut.count_r), 32'd0);
        check_val("ms_rst_empty", 32'(queueEmpty),  32'd1);
        check_val("ms_rst_ready", 32'(inputsReady), 32'd0);
        check_val("ms_rst_state", 32'(dut.state_r), 32'(LOAD));
        cycle();
        cycle();
        check_val("ms_after_state", 32'(dut.state_r), 32'(LOAD));
        check_val("ms_after_ready", 32'(inputsReady), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
